// File: rtl/hdmi_i2c_config_seq.sv
// hdmi_i2c_config_seq: walks the HDMI transmitter register list and issues one 2-byte I2C write per entry,
// with NACK retry and per-attempt timeout. Define HDMI_HPD_REINIT_EN to rerun the sequence on an HPD rise.
module hdmi_i2c_config_seq #(
    parameter int         NUM_REGS    = 32,
    parameter logic [7:0] SLAVE_ADDR  = 8'h72,
    parameter int         PWR_DLY     = 20000,
    parameter int         GAP_CYC     = 8,
    parameter int         RETRY_MAX   = 3,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic        PT_CK,
    input  logic        RESET_N,
    input  logic        START,
    input  logic        HPD,
    output logic [7:0]  LUT_INDEX,
    input  logic [15:0] LUT_DATA,
    output logic        GO,
    output logic [15:0] REG_DATA,
    output logic [7:0]  SLAVE_ADDRESS,
    output logic [7:0]  BYTE_NUM,
    input  logic        END_OK,
    input  logic        ACK_OK,
    output logic        BUSY,
    output logic        READY,
    output logic        ERROR,
    output logic [7:0]  NACK_CNT
);
    localparam logic [3:0] S_PWR     = 4'd0;
    localparam logic [3:0] S_LOAD    = 4'd1;
    localparam logic [3:0] S_LAUNCH  = 4'd2;
    localparam logic [3:0] S_WAIT_LO = 4'd3;
    localparam logic [3:0] S_WAIT_HI = 4'd4;
    localparam logic [3:0] S_CHECK   = 4'd5;
    localparam logic [3:0] S_GAP     = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;
    localparam logic [3:0] S_FAIL    = 4'd8;

    localparam logic [15:0] PWR_END  = 16'(PWR_DLY - 1);
    localparam logic [15:0] GAP_END  = 16'(GAP_CYC - 1);
    localparam logic [15:0] TO_END   = 16'(TIMEOUT_CYC - 1);
    localparam logic [7:0]  LAST_IDX = 8'(NUM_REGS - 1);
    localparam logic [2:0]  RMAX     = 3'(RETRY_MAX);

    logic [3:0]  state_q, state_d;
    logic [15:0] tmr_q, tmr_d;
    logic [7:0]  idx_q, idx_d;
    logic [2:0]  att_q, att_d;
    logic [7:0]  nack_q, nack_d;
    logic [15:0] data_q, data_d;
    logic        go_q, go_d;
    logic        to_q, to_d;
    logic        last_q, last_d;
    logic        start_q;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic        error_q, error_d;
    logic        start_rise, restart_req;

    assign start_rise = START & ~start_q;

`ifdef HDMI_HPD_REINIT_EN
    logic [2:0] hpd_sync_q;
    logic       hpd_pend_q, hpd_pend_d;

    // A pending HPD rise survives a busy sequence and is consumed once the sequence settles
    always_comb begin
        hpd_pend_d = (hpd_sync_q[1] & ~hpd_sync_q[2]) |
                     (hpd_pend_q & ~(state_q == S_DONE || state_q == S_FAIL));
    end

    always_ff @(posedge PT_CK or negedge RESET_N) begin
        if (!RESET_N) begin
            hpd_sync_q <= '0;
            hpd_pend_q <= 1'b0;
        end else begin
            hpd_sync_q <= {hpd_sync_q[1:0], HPD};
            hpd_pend_q <= hpd_pend_d;
        end
    end

    assign restart_req = start_rise | hpd_pend_q;
`else
    logic unused_hpd;
    assign unused_hpd  = HPD;
    assign restart_req = start_rise;
`endif

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        idx_d   = idx_q;
        att_d   = att_q;
        nack_d  = nack_q;
        data_d  = data_q;
        go_d    = 1'b1;
        to_d    = 1'b0;
        last_d  = last_q;
        case (state_q)
            S_PWR: begin
                tmr_d   = (tmr_q == PWR_END) ? 16'd0 : tmr_q + 16'd1;
                state_d = (tmr_q == PWR_END) ? S_LOAD : S_PWR;
            end
            S_LOAD: begin
                data_d  = LUT_DATA;
                tmr_d   = 16'd0;
                state_d = S_LAUNCH;
            end
            S_LAUNCH: begin
                go_d    = 1'b0;
                state_d = S_WAIT_LO;
            end
            S_WAIT_LO, S_WAIT_HI: begin
                tmr_d = tmr_q + 16'd1;
                if (state_q == S_WAIT_LO && !END_OK) begin
                    state_d = S_WAIT_HI;
                end else if (state_q == S_WAIT_HI && END_OK) begin
                    state_d = S_CHECK;
                end else if (tmr_q == TO_END) begin
                    state_d = S_CHECK;
                    to_d    = 1'b1;
                end
            end
            S_CHECK: begin
                tmr_d   = 16'd0;
                state_d = S_GAP;
                // A timed-out attempt is charged exactly like a NACK
                if (ACK_OK || to_q) begin
                    nack_d = (nack_q == 8'hFF) ? nack_q : nack_q + 8'd1;
                    if (att_q < RMAX) begin
                        att_d = att_q + 3'd1;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else begin
                    att_d  = 3'd0;
                    last_d = (idx_q == LAST_IDX);
                    idx_d  = (idx_q == LAST_IDX) ? idx_q : idx_q + 8'd1;
                end
            end
            S_GAP: begin
                tmr_d   = (tmr_q == GAP_END) ? tmr_q : tmr_q + 16'd1;
                state_d = (tmr_q != GAP_END) ? S_GAP : (last_q ? S_DONE : S_LOAD);
            end
            S_DONE, S_FAIL: begin
                if (restart_req) begin
                    state_d = S_LOAD;
                    idx_d   = 8'd0;
                    att_d   = 3'd0;
                    nack_d  = 8'd0;
                    last_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_PWR;
                tmr_d   = 16'd0;
            end
        endcase
        busy_d  = !(state_d == S_DONE || state_d == S_FAIL);
        ready_d = (state_d == S_DONE);
        error_d = (state_d == S_FAIL);
    end

    always_ff @(posedge PT_CK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q <= S_PWR;
            tmr_q   <= '0;
            idx_q   <= '0;
            att_q   <= '0;
            nack_q  <= '0;
            data_q  <= '0;
            go_q    <= 1'b1;
            to_q    <= 1'b0;
            last_q  <= 1'b0;
            start_q <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            idx_q   <= idx_d;
            att_q   <= att_d;
            nack_q  <= nack_d;
            data_q  <= data_d;
            go_q    <= go_d;
            to_q    <= to_d;
            last_q  <= last_d;
            start_q <= START;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            error_q <= error_d;
        end
    end

    assign LUT_INDEX     = idx_q;
    assign GO            = go_q;
    assign REG_DATA      = data_q;
    assign SLAVE_ADDRESS = SLAVE_ADDR;
    assign BYTE_NUM      = 8'd2;
    assign BUSY          = busy_q;
    assign READY         = ready_q;
    assign ERROR         = error_q;
    assign NACK_CNT      = nack_q;
endmodule

// File: tb/tb_hdmi_i2c_config_seq.sv
// tb_hdmi_i2c_config_seq: table-driven and randomized bench with a negedge I2C engine model and
// a per-entry retry reference model for the register-init sequencer.
module tb_hdmi_i2c_config_seq;
    localparam int N    = 3;
    localparam int PWR  = 16;
    localparam int GAP  = 4;
    localparam int RMAX = 3;
    localparam int TOUT = 64;

    typedef struct {
        logic [7:0] m0, m1, m2;
        bit         rd, er;
        int         nk, fi, nl;
    } vec_t;

    logic        PT_CK = 0, RESET_N = 1, START = 0, HPD = 0;
    logic [7:0]  LUT_INDEX, SLAVE_ADDRESS, BYTE_NUM, NACK_CNT;
    logic [15:0] LUT_DATA, REG_DATA;
    logic        GO, BUSY, READY, ERROR;
    logic        END_OK = 1, ACK_OK = 0;

    logic [15:0] lut [4];
    logic [7:0]  nack_mask [3];
    int          eng_att [3];
    bit          hang = 0;
    int          checks = 0, errors = 0, cyc = 0, t_kick = 0;
    int          log_idx [$];
    logic [15:0] log_dat [$];
    int          log_t [$];
    int          exp_idx [$];
    vec_t        tbl [6];

    hdmi_i2c_config_seq #(.NUM_REGS(N), .SLAVE_ADDR(8'h72), .PWR_DLY(PWR), .GAP_CYC(GAP),
                          .RETRY_MAX(RMAX), .TIMEOUT_CYC(TOUT)) dut (
        .PT_CK(PT_CK), .RESET_N(RESET_N), .START(START), .HPD(HPD),
        .LUT_INDEX(LUT_INDEX), .LUT_DATA(LUT_DATA), .GO(GO), .REG_DATA(REG_DATA),
        .SLAVE_ADDRESS(SLAVE_ADDRESS), .BYTE_NUM(BYTE_NUM), .END_OK(END_OK), .ACK_OK(ACK_OK),
        .BUSY(BUSY), .READY(READY), .ERROR(ERROR), .NACK_CNT(NACK_CNT)
    );

    assign LUT_DATA = lut[LUT_INDEX[1:0]];

    always #5 PT_CK = ~PT_CK;
    always @(posedge PT_CK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Engine: sees GO low at the negedge, runs a short transfer, answers ACK/NACK from the plan
    initial begin : engine
        int cnt, ix;
        bit pn, go_prev;
        cnt = 0; pn = 0; go_prev = 0;
        forever begin
            @(negedge PT_CK);
            if (!RESET_N) begin
                cnt = 0; END_OK = 1; ACK_OK = 0; go_prev = 0;
            end else begin
                if (!GO) chk("go_pulse_width", go_prev, 0);
                go_prev = !GO;
                if (cnt > 0) begin
                    cnt--;
                    if (cnt == 0) begin
                        END_OK = 1;
                        ACK_OK = pn;
                        chk("reg_data_held", REG_DATA, log_dat[log_dat.size()-1]);
                    end
                end else if (!GO) begin
                    ix = LUT_INDEX;
                    log_idx.push_back(ix);
                    log_dat.push_back(REG_DATA);
                    log_t.push_back(cyc);
                    if (!hang) begin
                        pn = (ix < N && eng_att[ix] < 8) ? nack_mask[ix][eng_att[ix]] : 1'b0;
                        if (ix < N) eng_att[ix]++;
                        END_OK = 0;
                        ACK_OK = 0;
                        cnt = $urandom_range(6, 3);
                    end
                end
            end
        end
    end

    // Reference: each entry gets up to RMAX+1 attempts; the first ACK moves on
    task automatic model(output bit rdy, output bit err, output int nk, output int fi);
        exp_idx.delete();
        nk = 0; rdy = 1; err = 0; fi = N - 1;
        for (int i = 0; i < N && !err; i++) begin
            for (int k = 0; k <= RMAX; k++) begin
                exp_idx.push_back(i);
                if (!nack_mask[i][k]) break;
                nk++;
                if (k == RMAX) begin
                    err = 1; rdy = 0; fi = i;
                end
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (BUSY && n < 5000) begin
            @(negedge PT_CK);
            n++;
        end
        chk({name, " idle_bound"}, BUSY, 0);
    endtask

    task automatic begin_run(input bit kick);
        log_idx.delete(); log_dat.delete(); log_t.delete();
        for (int i = 0; i < N; i++) eng_att[i] = 0;
        if (kick) begin
            @(negedge PT_CK);
            START = 1;
            t_kick = cyc;
            @(negedge PT_CK);
            START = 0;
        end
    endtask

    task automatic compare(input string name, input bit rd, input bit er, input int nk,
                           input int fi, input int nl);
        bit mr, me;
        int mn, mf;
        model(mr, me, mn, mf);
        chk({name, " launches"}, log_idx.size(), nl);
        for (int i = 0; i < exp_idx.size() && i < log_idx.size(); i++) begin
            chk({name, " idx"}, log_idx[i], exp_idx[i]);
            chk({name, " data"}, log_dat[i], lut[exp_idx[i]]);
        end
        chk({name, " ready"}, READY, rd);
        chk({name, " error"}, ERROR, er);
        chk({name, " nack_cnt"}, NACK_CNT, nk);
        chk({name, " lut_index"}, LUT_INDEX, fi);
        chk({name, " go_high"}, GO, 1);
    endtask

    task automatic check_reset_outputs(input string name);
        chk({name, " go"}, GO, 1);
        chk({name, " reg_data"}, REG_DATA, 0);
        chk({name, " lut_index"}, LUT_INDEX, 0);
        chk({name, " busy"}, BUSY, 1);
        chk({name, " ready"}, READY, 0);
        chk({name, " error"}, ERROR, 0);
        chk({name, " nack_cnt"}, NACK_CNT, 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        int t_rel, d, n;
        bit mr, me;
        int mn, mf;
        tbl[0] = '{8'h00, 8'h00, 8'h00, 1, 0, 0, 2, 3};
        tbl[1] = '{8'h00, 8'h01, 8'h00, 1, 0, 1, 2, 4};
        tbl[2] = '{8'h00, 8'h00, 8'hFF, 0, 1, 4, 2, 6};
        tbl[3] = '{8'h07, 8'h00, 8'h00, 1, 0, 3, 2, 6};
        tbl[4] = '{8'h0F, 8'h00, 8'h00, 0, 1, 4, 0, 4};
        tbl[5] = '{8'h00, 8'h05, 8'h03, 1, 0, 3, 2, 6};
        lut[0] = 16'h4110; lut[1] = 16'h9803; lut[2] = 16'hD6C0; lut[3] = 16'h0000;

        #1 RESET_N = 0;
        #2 check_reset_outputs("reset");
        chk("slave_address", SLAVE_ADDRESS, 8'h72);
        chk("byte_num", BYTE_NUM, 8'd2);
        repeat (2) @(negedge PT_CK);
        RESET_N = 1;
        t_rel = cyc;

        for (int v = 0; v < 6; v++) begin
            nack_mask[0] = tbl[v].m0; nack_mask[1] = tbl[v].m1; nack_mask[2] = tbl[v].m2;
            begin_run(v != 0);
            wait_idle($sformatf("vec%0d", v));
            compare($sformatf("vec%0d", v), tbl[v].rd, tbl[v].er, tbl[v].nk, tbl[v].fi, tbl[v].nl);
            d = (log_t.size() > 0) ? log_t[0] - (v == 0 ? t_rel : t_kick) : -1;
            if (v == 0) chk("pwr_delay", d >= PWR, 1);
            else chk($sformatf("vec%0d restart_latency", v), d >= 1 && d <= 6, 1);
        end

        // Engine never answers: each attempt runs out the timer
        hang = 1;
        for (int i = 0; i < N; i++) nack_mask[i] = 8'hFF;
        begin_run(1);
        wait_idle("timeout");
        compare("timeout", 0, 1, 4, 0, 4);
        for (int i = 0; i + 1 < log_t.size(); i++) begin
            d = log_t[i+1] - log_t[i];
            chk("timeout_spacing", d >= TOUT && d <= TOUT + GAP + 8, 1);
        end
        hang = 0;

        // START during WAIT_HI must be ignored
        for (int i = 0; i < N; i++) nack_mask[i] = 8'h00;
        begin_run(1);
        n = 0;
        while (END_OK && n < 200) begin
            @(negedge PT_CK);
            n++;
        end
        chk("wait_hi_reach", END_OK, 0);
        @(negedge PT_CK);
        START = 1;
        repeat (2) @(negedge PT_CK);
        START = 0;
        wait_idle("start_in_wait_hi");
        compare("start_in_wait_hi", 1, 0, 0, 2, 3);

        // Reset in the middle of a retried write
        nack_mask[0] = 8'h01; nack_mask[1] = 8'h00; nack_mask[2] = 8'h00;
        begin_run(1);
        n = 0;
        while (!(LUT_INDEX == 1 && !END_OK) && n < 300) begin
            @(negedge PT_CK);
            n++;
        end
        chk("midwrite_nack_seen", NACK_CNT, 1);
        #2 RESET_N = 0;
        #1 check_reset_outputs("midwrite_reset");
        @(negedge PT_CK);
        RESET_N = 1;
        t_rel = cyc;
        begin_run(0);
        wait_idle("after_reset");
        compare("after_reset", 1, 0, 1, 2, 4);
        d = (log_t.size() > 0) ? log_t[0] - t_rel : -1;
        chk("after_reset pwr_delay", d >= PWR, 1);

        // HPD rise while busy
        for (int i = 0; i < N; i++) nack_mask[i] = 8'h00;
        begin_run(1);
        n = 0;
        while (LUT_INDEX != 1 && n < 300) begin
            @(negedge PT_CK);
            n++;
        end
        HPD = 1;
        wait_idle("hpd_first");
`ifdef HDMI_HPD_REINIT_EN
        n = 0;
        while (!BUSY && n < 20) begin
            @(negedge PT_CK);
            n++;
        end
        chk("hpd_rerun_started", BUSY, 1);
        wait_idle("hpd_second");
        chk("hpd launches", log_idx.size(), 2 * N);
`else
        repeat (30) @(negedge PT_CK);
        chk("hpd_no_rerun busy", BUSY, 0);
        chk("hpd launches", log_idx.size(), N);
`endif
        chk("hpd ready", READY, 1);
        HPD = 0;

        // Randomized plans against the reference model
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < N; i++) begin
                lut[i] = 16'($urandom);
                nack_mask[i] = 8'($urandom & $urandom & (r[0] ? $urandom : 32'hFFFF_FFFF));
            end
            model(mr, me, mn, mf);
            begin_run(1);
            wait_idle($sformatf("rand%0d", r));
            compare($sformatf("rand%0d", r), mr, me, mn, mf, exp_idx.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
